// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared widths, line geometry and FSM encoding for the instruction cache
package icache_pkg;

  localparam int ADDR_WID        = 32;
  localparam int ICACHE_LINE_SIZ = 16;
  localparam int ICACHE_LINE_WID = ICACHE_LINE_SIZ * 8;
  localparam int INST_WID        = 32;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MISS = 1'b1
  } icache_state_e;

endpackage

// File: rtl/icache_if.sv
// rtl/icache_if.sv - fetch-side and memory-controller-side bundles for the instruction cache

// Fetch unit -> cache: the fetch unit is the master, the cache the slave.
interface icache_ifu_if import icache_pkg::*; ();
  logic                ifu_valid;
  logic [ADDR_WID-1:0] ifu_pc;
  logic                rollback;
  logic                ifu_hit;
  logic [INST_WID-1:0] ifu_inst;

  modport master (output ifu_valid, ifu_pc, rollback, input ifu_hit, ifu_inst);
  modport slave  (input ifu_valid, ifu_pc, rollback, output ifu_hit, ifu_inst);
endinterface

// Cache -> memory controller line fetch: the cache is the master, the controller the slave.
interface icache_mc_if import icache_pkg::*; #(
  parameter int LINE_BYTES = ICACHE_LINE_SIZ
) ();
  logic                    mc_en;
  logic [ADDR_WID-1:0]     mc_pc;
  logic                    mc_done;
  logic [LINE_BYTES*8-1:0] mc_data;

  modport master (output mc_en, mc_pc, input mc_done, mc_data);
  modport slave  (input mc_en, mc_pc, output mc_done, mc_data);
endinterface

// File: rtl/icache_array.sv
// rtl/icache_array.sv - valid/tag/data storage, combinational read, single synchronous write
module icache_array import icache_pkg::*; #(
  parameter int LINES  = 64,
  parameter int IDX_W  = 6,
  parameter int TAG_W  = 22,
  parameter int LINE_W = ICACHE_LINE_WID
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [LINE_W-1:0] rd_data,
  input  logic              we,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [LINE_W-1:0] wr_data
);

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [LINE_W-1:0] data_mem [LINES];

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_data  = data_mem[rd_idx];

  // Valid bits are the only reset state; a fill marks its line valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (we) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  // Tag and data are meaningless until valid, so they carry no reset.
  always_ff @(posedge clk) begin
    if (we) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
  end

endmodule

// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped read-only instruction cache with line-fill miss handling
module icache import icache_pkg::*; #(
  parameter int LINE_BYTES = ICACHE_LINE_SIZ,
  parameter int LINES      = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rdy,
  icache_ifu_if.slave  ifu,
  icache_mc_if.master  mc
);

  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int IDX_W  = $clog2(LINES);
  localparam int TAG_W  = ADDR_WID - OFF_W - IDX_W;
  localparam int LINE_W = LINE_BYTES * 8;

  icache_state_e       state;
  logic                abandoned;
  logic [ADDR_WID-1:0] req_pc;

  logic                rd_valid;
  logic [TAG_W-1:0]    rd_tag;
  logic [LINE_W-1:0]   rd_data;
  logic                rd_hit;
  logic                fill_we;

  logic [OFF_W-1:0]    rd_wsel;
  logic [OFF_W-1:0]    fill_wsel;
  logic [LINE_W-1:0]   rd_line_sh;
  logic [LINE_W-1:0]   fill_line_sh;
  logic [INST_WID-1:0] hit_word;
  logic [INST_WID-1:0] fill_word;

  // Lookup uses the live fetch address; the hit compare is against the stored tag.
  assign rd_hit = rd_valid && (rd_tag == ifu.ifu_pc[ADDR_WID-1 -: TAG_W]);

  // Word select: shift the line right by whole words so word 0 lands in the low bits.
  assign rd_wsel      = ifu.ifu_pc[OFF_W-1:0] >> 2;
  assign fill_wsel    = req_pc[OFF_W-1:0] >> 2;
  assign rd_line_sh   = rd_data >> {rd_wsel, 5'd0};
  assign fill_line_sh = mc.mc_data >> {fill_wsel, 5'd0};
  assign hit_word     = rd_line_sh[INST_WID-1:0];
  assign fill_word    = fill_line_sh[INST_WID-1:0];

  // The fill is installed even for an abandoned request; its data is still correct.
  assign fill_we = rdy && (state == ST_MISS) && mc.mc_done;

  icache_array #(
    .LINES  (LINES),
    .IDX_W  (IDX_W),
    .TAG_W  (TAG_W),
    .LINE_W (LINE_W)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (ifu.ifu_pc[OFF_W +: IDX_W]),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .we       (fill_we),
    .wr_idx   (req_pc[OFF_W +: IDX_W]),
    .wr_tag   (req_pc[ADDR_WID-1 -: TAG_W]),
    .wr_data  (mc.mc_data)
  );

  // IDLE/MISS control with registered hit, instruction and line-request outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      abandoned    <= 1'b0;
      req_pc       <= '0;
      ifu.ifu_hit  <= 1'b0;
      ifu.ifu_inst <= '0;
      mc.mc_en     <= 1'b0;
      mc.mc_pc     <= '0;
    end else if (!rdy) begin
      ifu.ifu_hit <= 1'b0;
    end else begin
      ifu.ifu_hit <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ifu.ifu_valid && !ifu.rollback) begin
            if (rd_hit) begin
              ifu.ifu_hit  <= 1'b1;
              ifu.ifu_inst <= hit_word;
            end else begin
              mc.mc_en  <= 1'b1;
              mc.mc_pc  <= {ifu.ifu_pc[ADDR_WID-1:OFF_W], {OFF_W{1'b0}}};
              req_pc    <= ifu.ifu_pc;
              abandoned <= 1'b0;
              state     <= ST_MISS;
            end
          end
        end
        ST_MISS: begin
          // mc_en stays up until done: the controller completes a started line regardless.
          if (mc.mc_done) begin
            mc.mc_en <= 1'b0;
            if (!abandoned && !ifu.rollback) begin
              ifu.ifu_hit  <= 1'b1;
              ifu.ifu_inst <= fill_word;
            end
            abandoned <= 1'b0;
            state     <= ST_IDLE;
          end else if (ifu.rollback) begin
            abandoned <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - randomized scoreboard bench for the instruction cache
module tb_icache;
  import icache_pkg::*;

  localparam int LB       = 16;
  localparam int LINES    = 64;
  localparam int WORDS    = LB / 4;
  localparam int SET_SPAN = LB * LINES;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rdy = 1'b1;
  logic rdy_s = 1'b1;

  always #5 clk = ~clk;

  icache_ifu_if                      ifu_bus ();
  icache_mc_if #(.LINE_BYTES(LB))    mc_bus ();

  icache #(.LINE_BYTES(LB), .LINES(LINES)) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .ifu (ifu_bus),
    .mc  (mc_bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];
  logic [31:0] exp_mc_q[$];
  bit          m_valid [LINES];
  int unsigned m_tag   [LINES];

  int   stall_cnt     = 0;
  bit   stall_en      = 0;
  bit   spur_en       = 0;
  bit   stall_at_done = 0;
  int   c_state       = 0;
  int   c_wait        = 0;
  logic [31:0] c_pc   = '0;
  bit   spur          = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic fail_event(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event occurred, required none", name);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0104) return 32'h0000_0513;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [LB*8-1:0] line_of(input logic [31:0] base);
    logic [LB*8-1:0] l;
    for (int w = 0; w < WORDS; w++) l[w*32 +: 32] = mem_word(base + 32'(w * 4));
    return l;
  endfunction

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / LB) % LINES);
  endfunction

  function automatic bit model_hit(input logic [31:0] pc);
    return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == pc / SET_SPAN);
  endfunction

  // Reference: a miss requests the aligned line and installs it; a hit does not touch memory.
  task automatic model_access(input logic [31:0] pc, output bit hit);
    hit = model_hit(pc);
    if (!hit) exp_mc_q.push_back(pc & ~32'(LB - 1));
    m_valid[idx_of(pc)] = 1'b1;
    m_tag[idx_of(pc)]   = pc / SET_SPAN;
  endtask

  always @(posedge clk) rdy_s <= rdy;

  // Memory controller model plus global rdy generator.
  initial begin
    mc_bus.mc_done = 1'b0;
    mc_bus.mc_data = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        mc_bus.mc_done = 1'b0;
        c_state = 0;
        spur = 0;
        stall_cnt = 0;
        rdy = 1'b1;
        continue;
      end
      if (spur) begin
        mc_bus.mc_done = 1'b0;
        spur = 0;
      end
      case (c_state)
        0: begin
          if (mc_bus.mc_en) begin
            if (exp_mc_q.size() == 0) fail_event("unexpected mc request");
            else check("mc_pc", mc_bus.mc_pc, exp_mc_q.pop_front());
            c_pc = mc_bus.mc_pc;
            c_wait = $urandom_range(1, 4);
            c_state = 1;
          end else if (spur_en && $urandom_range(0, 7) == 0) begin
            for (int w = 0; w < WORDS; w++) mc_bus.mc_data[w*32 +: 32] = $urandom;
            mc_bus.mc_done = 1'b1;
            spur = 1;
          end
        end
        1: begin
          check("mc_en held in miss", {31'd0, mc_bus.mc_en}, 32'd1);
          check("mc_pc stable", mc_bus.mc_pc, c_pc);
          if (rdy_s) c_wait--;
          if (c_wait <= 0) begin
            mc_bus.mc_data = line_of(c_pc);
            mc_bus.mc_done = 1'b1;
            c_state = 2;
            if (stall_at_done) stall_cnt = 3;
          end
        end
        default: begin
          if (rdy_s) begin
            check("mc_en low after done", {31'd0, mc_bus.mc_en}, 32'd0);
            mc_bus.mc_done = 1'b0;
            c_state = 0;
          end else begin
            check("mc_en held in stall", {31'd0, mc_bus.mc_en}, 32'd1);
          end
        end
      endcase
      if (stall_cnt > 0) begin
        rdy = 1'b0;
        stall_cnt--;
      end else if (stall_en) begin
        rdy = ($urandom_range(0, 3) != 0);
      end else begin
        rdy = 1'b1;
      end
    end
  end

  // Scoreboard monitor: every ifu_hit consumes one expected instruction.
  always @(negedge clk) begin
    if (rst) begin
      if (!rdy_s) check("ifu_hit low in stall", {31'd0, ifu_bus.ifu_hit}, 32'd0);
      if (ifu_bus.ifu_hit) begin
        if (exp_q.size() == 0) fail_event("unexpected ifu_hit");
        else check("ifu_inst", ifu_bus.ifu_inst, exp_q.pop_front());
      end
    end
  end

  task automatic fetch(input logic [31:0] pc, input bit chk_lat);
    bit hit;
    int eff = 0;
    int n = 0;
    model_access(pc, hit);
    exp_q.push_back(mem_word(pc));
    ifu_bus.ifu_valid = 1'b1;
    ifu_bus.ifu_pc = pc;
    while (1) begin
      @(negedge clk);
      n++;
      if (rdy_s) begin
        eff++;
        if (!hit && chk_lat && eff == 1) check("miss raises mc_en", {31'd0, mc_bus.mc_en}, 32'd1);
      end
      if (ifu_bus.ifu_hit) break;
      if (n > 200) begin
        fail_event("fetch timeout");
        break;
      end
    end
    if (hit && chk_lat) begin
      check("hit latency", eff, 32'd1);
      check("hit keeps mc_en low", {31'd0, mc_bus.mc_en}, 32'd0);
    end
    ifu_bus.ifu_valid = 1'b0;
  endtask

  task automatic wait_effective();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rdy_s && n < 100);
  endtask

  task automatic fetch_rollback(input logic [31:0] pc);
    bit hit;
    model_access(pc, hit);
    ifu_bus.ifu_valid = 1'b1;
    ifu_bus.ifu_pc = pc;
    wait_effective();
    check("rollback miss mc_en", {31'd0, mc_bus.mc_en}, 32'd1);
    ifu_bus.rollback = 1'b1;
    ifu_bus.ifu_valid = 1'b0;
    wait_effective();
    ifu_bus.rollback = 1'b0;
  endtask

  task automatic wait_ctrl_idle();
    int n = 0;
    while ((c_state != 0 || mc_bus.mc_en) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) fail_event("controller idle timeout");
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit after_rb;
    int n;
    logic [31:0] pc;
    ifu_bus.ifu_valid = 1'b0;
    ifu_bus.ifu_pc = '0;
    ifu_bus.rollback = 1'b0;
    repeat (3) @(negedge clk);
    check("reset mc_en", {31'd0, mc_bus.mc_en}, 32'd0);
    check("reset mc_pc", mc_bus.mc_pc, 32'd0);
    check("reset ifu_hit", {31'd0, ifu_bus.ifu_hit}, 32'd0);
    check("reset ifu_inst", ifu_bus.ifu_inst, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    fetch(32'h0000_0104, 1);
    fetch(32'h0000_0108, 1);
    fetch(32'h0000_010C, 1);
    fetch(32'h0000_0500, 1);
    fetch(32'h0000_0100, 1);

    ifu_bus.ifu_valid = 1'b1;
    ifu_bus.ifu_pc = 32'h0000_2000;
    ifu_bus.rollback = 1'b1;
    @(negedge clk);
    check("idle rollback no mc_en", {31'd0, mc_bus.mc_en}, 32'd0);
    check("idle rollback no hit", {31'd0, ifu_bus.ifu_hit}, 32'd0);
    ifu_bus.ifu_valid = 1'b0;
    ifu_bus.rollback = 1'b0;
    @(negedge clk);

    fetch_rollback(32'h0000_3000);
    wait_ctrl_idle();
    fetch(32'h0000_3004, 1);

    stall_cnt = 3;
    @(negedge clk);
    fetch(32'h0000_3008, 1);

    stall_at_done = 1;
    fetch(32'h0000_4000, 1);
    stall_at_done = 0;

    ifu_bus.ifu_valid = 1'b1;
    ifu_bus.ifu_pc = 32'h0000_5000;
    begin
      bit hit;
      model_access(32'h0000_5000, hit);
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mc_bus.mc_en && n < 20);
    #2 rst = 1'b0;
    #1;
    check("async reset mc_en", {31'd0, mc_bus.mc_en}, 32'd0);
    check("async reset ifu_hit", {31'd0, ifu_bus.ifu_hit}, 32'd0);
    check("async reset mc_pc", mc_bus.mc_pc, 32'd0);
    ifu_bus.ifu_valid = 1'b0;
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
    exp_q.delete();
    exp_mc_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    fetch(32'h0000_0108, 1);

    stall_en = 1;
    spur_en = 1;
    after_rb = 0;
    for (int it = 0; it < 300; it++) begin
      pc = 32'($urandom_range(0, 3) * SET_SPAN + $urandom_range(0, 7) * LB
               + $urandom_range(0, WORDS - 1) * 4);
      if (!after_rb && !model_hit(pc) && $urandom_range(0, 7) == 0) begin
        fetch_rollback(pc);
        after_rb = 1;
      end else begin
        fetch(pc, !after_rb);
        after_rb = 0;
      end
    end
    stall_en = 0;
    spur_en = 0;
    repeat (20) @(negedge clk);
    check("hit queue drained", exp_q.size(), 32'd0);
    check("mc queue drained", exp_mc_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/icache.md
# icache

Direct-mapped instruction cache that sits between the instruction fetch unit and the memory controller. It serves 32-bit instruction fetches on a hit and, on a miss, requests a full line over the controller's line-fetch handshake (`if_en` / `if_pc` / `if_done` / `if_data`), installs it, and returns the instruction. It is the initiator end of that handshake: it supplies the request that the memory controller byte-fetches into a line.

## Interface
- `LINE_BYTES`, default 16: bytes per line, equal to `ICACHE_LINE_SIZ`, power of two, at least 4.
- `LINES`, default 64: number of lines, power of two.
- `clk` in 1: the single clock.
- `rst` in 1: reset, asynchronous and active-low.
- `rdy` in 1: global ready; when low, all state and outputs freeze.
- `rollback` in 1: pipeline flush; abandons the current fetch request.
- `ifu_valid` in 1: fetch request.
- `ifu_pc` in 32: fetch address, 4-byte aligned.
- `ifu_hit` out 1: one-cycle pulse; `ifu_inst` is valid for the pending request.
- `ifu_inst` out 32: fetched instruction, little-endian.
- `mc_en` out 1: line request to the memory controller (its `if_en`).
- `mc_pc` out 32: line-aligned request address (its `if_pc`).
- `mc_done` in 1: one-cycle pulse; line data is valid (its `if_done`).
- `mc_data` in `LINE_BYTES*8`: line data; byte i is at bits [8i+7:8i] (its `if_data`).

## Operation
- **Address split:**
  - offset = `pc[log2(LINE_BYTES)-1:0]`
  - index = next `log2(LINES)` bits
  - tag = remaining upper bits
  - word select = `offset[..:2]`
- **Storage per line:** valid bit, tag, data. All valid bits are cleared on reset; data and tags are not reset.
- **State IDLE:**
  - `ifu_valid` & !`rollback` & hit: register the selected word into `ifu_inst` and pulse `ifu_hit`.
  - `ifu_valid` & !`rollback` & miss: assert `mc_en`, set `mc_pc = {ifu_pc[31:off], 0}`, latch the request pc, go to MISS.
- **State MISS:** hold `mc_en` and `mc_pc` stable. On `mc_done`:
  - drop `mc_en`;
  - write `mc_data`, the tag and valid=1 into the index;
  - unless the request was abandoned, pulse `ifu_hit` with the word forwarded from `mc_data`;
  - go to IDLE.
- **Rollback:**
  - In IDLE, a request in the same cycle is ignored.
  - In MISS, the request is marked abandoned. The fill still completes and is installed, because the data is correct for its address. No `ifu_hit` is produced for it, and `mc_en` is not withdrawn early, since the controller finishes any started line anyway.
- **IFU contract:** hold `ifu_valid` and `ifu_pc` stable until `ifu_hit` or `rollback`. Requests arriving in MISS are not accepted; they are re-evaluated in IDLE.
- **Replacement:** a conflict miss overwrites the line unconditionally. There is no write path, as the cache is read-only.
- **`rdy` low:** no state change, `ifu_hit` held 0, `mc_en` held at its value.
- **Reset, async or mid-miss:**
  - state IDLE;
  - `mc_en` = 0, `mc_pc` = 0, `ifu_hit` = 0, `ifu_inst` = 0;
  - all valid bits = 0;
  - the abandoned flag is cleared.

## Timing
- **Hit latency:** request sampled at edge N; `ifu_hit` = 1 and `ifu_inst` are valid in the cycle after N; `ifu_hit` drops the cycle after that.
- **Miss:**
  - request sampled at edge N; `mc_en` = 1 from the cycle after N.
  - `mc_done` sampled at edge M; `mc_en` = 0 and `ifu_hit` = 1 in the cycle after M.
  - A request to the same line sampled at edge M+1 hits.
- **Handshake with the controller:** `mc_en` must be low in the cycle after `mc_done`. The controller spends that cycle clearing its done flag, so no duplicate fetch is issued.
- **`mc_done` outside MISS:** ignored.
- **Back-to-back hits:** one per cycle while `ifu_valid` is held; the IFU changes pc after each `ifu_hit`.

## Structure
- The shared defines header holds `ADDR_WID`, `ICACHE_LINE_SIZ` and `ICACHE_LINE_WID`; the block uses those, not local literals.
- Sub-module `icache_array`: valid/tag/data storage with a combinational read port and a synchronous single write port, plus asynchronous clearing of the valid bits.
- The top level contains the 2-state FSM, the abandoned flag, word select and forwarding.

## Test plan
- **Cold miss:** after reset, fetch `0x00000104`. Expect `mc_en` = 1 with `mc_pc` = `0x00000100`. Return `mc_data` with bytes 4..7 = `13 05 00 00`. Expect `ifu_hit` with `ifu_inst` = `0x00000513` one cycle after `mc_done`.
- **Hit after fill:** fetch `0x00000108` and then `0x0000010C`. Expect `mc_en` to stay 0 and `ifu_hit` one cycle after each request, with the correct words.
- **Conflict:** fetch `0x00000500`, which has the same index as `0x100` (64×16 B sets, so the index repeats every 1 KiB) and a different tag. Expect a miss, then a re-fetch of `0x100` that misses again.
- **Rollback mid-miss:** pulse `rollback` while in MISS. Expect no `ifu_hit` on `mc_done`, and `mc_en` dropping in the cycle after `mc_done`. A later fetch of that line hits.
- **`rdy` stall:** hold `rdy` = 0 for 3 cycles around `mc_done` and a hit request. Expect outputs frozen, then the normal response once `rdy` returns.
- **Reset mid-miss:** assert `rst` = 0 while `mc_en` = 1. Expect immediate `mc_en` = 0 and `ifu_hit` = 0. After reset is released, a previously filled line misses.
